// File: rtl/aes_encrypt_iter_checksum.sv
// Iterative AES encryptor: one round per clock for AES-128/192/256, with a
// 32-bit XOR-fold checksum accumulated over every round state 0..Nr.
module aes_encrypt_iter_checksum #(
    parameter int N  = 128,
    parameter int Nr = 10,
    parameter int Nk = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in,
    input  logic [N-1:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out,
    output logic [31:0]  state_checksum,
    output logic         busy
);
    localparam int RW = $clog2(Nr + 1);
    localparam int NW = 4 * (Nr + 1);
    localparam logic [RW-1:0] LAST_RND = RW'(Nr);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Byte i of the block sits at bits 127-8i; the state is column-major.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    function automatic logic [31:0] fold(input logic [127:0] s);
        return s[127:96] ^ s[95:64] ^ s[63:32] ^ s[31:0];
    endfunction

    function automatic logic [NW*32-1:0] key_expand(input logic [N-1:0] k);
        logic [31:0]      w [NW];
        logic [31:0]      t;
        logic [7:0]       rc;
        logic [NW*32-1:0] ks;
        rc = 8'h01;
        for (int i = 0; i < Nk; i++) w[i] = k[N-1-32*i -: 32];
        for (int i = Nk; i < NW; i++) begin
            t = w[i-1];
            if (i % Nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (Nk > 6 && i % Nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-Nk] ^ t;
        end
        for (int i = 0; i < NW; i++) ks[NW*32-1-32*i -: 32] = w[i];
        return ks;
    endfunction

    state_e          state_q, state_d;
    logic [RW-1:0]   rnd_q, rnd_d;
    logic [127:0]    pt_q, pt_d;
    logic [N-1:0]    key_q, key_d;
    logic [127:0]    st_q, st_d;
    logic [31:0]     cks_q, cks_d;
    logic [127:0]    out_q, out_d;
    logic [31:0]     sum_q, sum_d;
    logic [NW*32-1:0] ks;
    logic [127:0]    rk, ss, st_new;

    assign ks = key_expand(key_q);

    always_comb begin
        // NOTE: every variable gets its hold value first, so no branch of the case can infer a latch.
        state_d = state_q;
        rnd_d   = rnd_q;
        pt_d    = pt_q;
        key_d   = key_q;
        st_d    = st_q;
        cks_d   = cks_q;
        out_d   = out_q;
        sum_d   = sum_q;

        rk = ks[NW*32-1 - 128*int'(rnd_q) -: 128];
        ss = sub_shift(st_q);
        if (rnd_q == '0)           st_new = pt_q ^ rk;
        else if (rnd_q == LAST_RND) st_new = ss ^ rk;
        else                        st_new = mix_columns(ss) ^ rk;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pt_d    = in;
                    key_d   = key;
                    rnd_d   = '0;
                    cks_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                st_d  = st_new;
                cks_d = cks_q ^ fold(st_new);
                rnd_d = rnd_q + 1'b1;
                if (rnd_q == LAST_RND) begin
                    out_d   = st_new;
                    sum_d   = cks_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            pt_q    <= '0;
            key_q   <= '0;
            st_q    <= '0;
            cks_q   <= '0;
            out_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            pt_q    <= pt_d;
            key_q   <= key_d;
            st_q    <= st_d;
            cks_q   <= cks_d;
            out_q   <= out_d;
            sum_q   <= sum_d;
        end
    end

    assign in_ready       = (state_q == IDLE);
    assign busy           = (state_q == RUN);
    assign out_valid      = (state_q == DONE);
    assign out            = out_q;
    assign state_checksum = sum_q;

endmodule

// File: tb/tb_aes_encrypt_iter_checksum.sv
// Directed and randomized bench for aes_encrypt_iter_checksum; the reference
// model derives its S-box from GF(2^8) inversion rather than a table.
module tb_aes_encrypt_iter_checksum;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [127:0] pt;
    logic [255:0] kb;
    logic         iv [3];
    logic         ir [3];
    logic         ov [3];
    logic         ordy [3];
    logic         bz [3];
    logic [127:0] ct_w [3];
    logic [31:0]  ck_w [3];

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] sb_m [256];

    aes_encrypt_iter_checksum #(.N(128), .Nr(10), .Nk(4)) u_aes128 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in(pt),
        .key(kb[255 -: 128]), .out_valid(ov[0]), .out_ready(ordy[0]), .out(ct_w[0]),
        .state_checksum(ck_w[0]), .busy(bz[0]));

    aes_encrypt_iter_checksum #(.N(192), .Nr(12), .Nk(6)) u_aes192 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in(pt),
        .key(kb[255 -: 192]), .out_valid(ov[1]), .out_ready(ordy[1]), .out(ct_w[1]),
        .state_checksum(ck_w[1]), .busy(bz[1]));

    aes_encrypt_iter_checksum #(.N(256), .Nr(14), .Nk(8)) u_aes256 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in(pt),
        .key(kb), .out_valid(ov[2]), .out_ready(ordy[2]), .out(ct_w[2]),
        .state_checksum(ck_w[2]), .busy(bz[2]));

    typedef struct {
        string        name;
        int           sel;
        logic [127:0] pt;
        logic [255:0] key;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [31:0] sub_w(input logic [31:0] w);
        return {sb_m[w[31:24]], sb_m[w[23:16]], sb_m[w[15:8]], sb_m[w[7:0]]};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb_m[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    // Key occupies the top nk words of k.
    task automatic aes_model(input logic [127:0] p, input logic [255:0] k, input int nk,
                             output logic [127:0] ct, output logic [31:0] ck);
        int         nr;
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [7:0]  s [16];
        logic [7:0]  u [16];
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_w(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int b = 0; b < 16; b++) s[b] = p[127-8*b -: 8];
        ck = '0;
        for (int r = 0; r <= nr; r++) begin
            if (r > 0) begin
                for (int b = 0; b < 16; b++) u[b] = sb_m[s[b]];
                for (int b = 0; b < 16; b++) s[b] = u[(b % 4) + 4 * (((b / 4) + (b % 4)) % 4)];
                if (r < nr) begin
                    for (int c = 0; c < 4; c++) begin
                        for (int j = 0; j < 4; j++) u[j] = s[4*c+j];
                        s[4*c+0] = gmul(8'h02, u[0]) ^ gmul(8'h03, u[1]) ^ u[2] ^ u[3];
                        s[4*c+1] = u[0] ^ gmul(8'h02, u[1]) ^ gmul(8'h03, u[2]) ^ u[3];
                        s[4*c+2] = u[0] ^ u[1] ^ gmul(8'h02, u[2]) ^ gmul(8'h03, u[3]);
                        s[4*c+3] = gmul(8'h03, u[0]) ^ u[1] ^ u[2] ^ gmul(8'h02, u[3]);
                    end
                end
            end
            for (int c = 0; c < 4; c++) begin
                for (int j = 0; j < 4; j++) s[4*c+j] ^= w[4*r+c][31-8*j -: 8];
                ck ^= {s[4*c], s[4*c+1], s[4*c+2], s[4*c+3]};
            end
        end
        for (int b = 0; b < 16; b++) ct[127-8*b -: 8] = s[b];
    endtask

    task automatic start_job(input int sel, input logic [127:0] p, input logic [255:0] k);
        int g;
        g = 0;
        while (!ir[sel] && g < 50) begin
            tick();
            g++;
        end
        pt      = p;
        kb      = k;
        iv[sel] = 1'b1;
        tick();
        iv[sel] = 1'b0;
    endtask

    // One full job: accept, wait for out_valid, check result, release.
    task automatic run_vec(input string name, input int sel, input logic [127:0] p,
                           input logic [255:0] k, input logic [127:0] exp_ct, input bit scramble);
        logic [127:0] mct;
        logic [31:0]  mck;
        int           lat;
        int           g;
        aes_model(p, k, 4 + 2 * sel, mct, mck);
        start_job(sel, p, k);
        check({name, "_busy"}, {ir[sel], bz[sel], ov[sel]}, 3'b010);
        lat = 0;
        while (!ov[sel] && lat < 40) begin
            if (scramble) begin
                pt        = rand128();
                kb        = {rand128(), rand128()};
                ordy[sel] = 1'($urandom_range(0, 1));
            end
            tick();
            lat++;
        end
        check({name, "_lat"}, lat, 11 + 2 * sel);
        check({name, "_ct"}, ct_w[sel], exp_ct);
        check({name, "_cks"}, ck_w[sel], mck);
        g = 0;
        do begin
            ordy[sel] = scramble ? 1'($urandom_range(0, 1)) : 1'b1;
            if (scramble) pt = rand128();
            tick();
            g++;
            if (ov[sel]) check({name, "_hold"}, {ct_w[sel], ck_w[sel]}, {exp_ct, mck});
        end while (ov[sel] && g < 40);
        ordy[sel] = 1'b0;
        check({name, "_release"}, {ov[sel], ir[sel], bz[sel]}, 3'b010);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] mct, p;
        logic [31:0]  mck;
        logic         seen_ov;
        int           lat;
        int           sel;

        rst_n = 1'b0;
        pt    = '0;
        kb    = '0;
        for (int i = 0; i < 3; i++) begin
            iv[i]   = 1'b0;
            ordy[i] = 1'b0;
        end
        build_sbox();

        vecs[0] = '{"t1_b", 0, 128'h3243f6a8885a308d313198a2e0370734,
                    {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 128'h3925841d02dc09fbdc118597196a0b32};
        vecs[1] = '{"t2_c1", 0, 128'h00112233445566778899aabbccddeeff,
                    {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[2] = '{"t2_c2", 1, 128'h00112233445566778899aabbccddeeff,
                    {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                    128'hdda97ca4864cdfe06eaf70a0ec0d7191};
        vecs[3] = '{"t2_c3", 2, 128'h00112233445566778899aabbccddeeff,
                    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    128'h8ea2b7ca516745bfeafc49904b496089};
        vecs[4] = '{"t6_zero", 0, 128'h0, 256'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_%0d", i), {ov[i], ir[i], bz[i], ct_w[i], ck_w[i]}, {3'b010, 160'h0});
        end

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i].name, vecs[i].sel, vecs[i].pt, vecs[i].key, vecs[i].ct, 1'b0);
        end

        // Result held under back-pressure; in_valid offered during DONE is ignored.
        aes_model(vecs[0].pt, vecs[0].key, 4, mct, mck);
        start_job(0, vecs[0].pt, vecs[0].key);
        lat = 0;
        while (!ov[0] && lat < 40) begin
            tick();
            lat++;
        end
        for (int c = 0; c < 20; c++) begin
            iv[0] = 1'b1;
            pt    = ~pt;
            tick();
            check("t3_hold", {ov[0], ir[0], ct_w[0], ck_w[0]}, {2'b10, vecs[0].ct, mck});
        end
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        tick();
        ordy[0] = 1'b0;
        check("t3_release", {ov[0], ir[0], bz[0]}, 3'b010);
        tick();
        check("t3_no_accept", {ir[0], bz[0]}, 2'b10);

        // Reset pulse while rnd = 5 aborts the job.
        start_job(0, vecs[0].pt, vecs[0].key);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t4_reset", {ov[0], ir[0], bz[0], ct_w[0], ck_w[0]}, {3'b010, 160'h0});
        seen_ov = 1'b0;
        repeat (15) begin
            tick();
            seen_ov |= ov[0];
        end
        check("t4_no_out_valid", seen_ov, 1'b0);
        run_vec("t4_fresh", 0, vecs[0].pt, vecs[0].key, vecs[0].ct, 1'b0);

        // Random jobs across all key sizes with changing inputs and random out_ready.
        for (int j = 0; j < 100; j++) begin
            sel = $urandom_range(0, 2);
            p   = rand128();
            kb  = {rand128(), rand128()};
            aes_model(p, kb, 4 + 2 * sel, mct, mck);
            run_vec($sformatf("t5_%0d", j), sel, p, kb, mct, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
